// File: rtl/aes_block_stream_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// | Module   : aes_block_stream_pkg                                           |
// | Brief    : Shared AES block/byte types and stream FSM encoding.           |
// | Revision : 1.0                                                            |
// -----------------------------------------------------------------------------
package aes_block_stream_pkg;

   typedef logic [127:0] aes_block_t;
   typedef logic [7:0]   aes_byte_t;

   localparam int AES_BLK_BYTES = 16;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      LOAD  = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } stream_state_e;

   // MSB bit position of byte idx, where byte 0 is the most significant byte.
   function automatic logic [6:0] byte_msb(input logic [3:0] idx);
      return {~idx, 3'b111};
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_block_stream.sv
`default_nettype none
// -----------------------------------------------------------------------------
// | Module   : aes_block_stream                                               |
// | Brief    : Byte-serial packer/unpacker around the AES encrypt core.       |
// |            Optional watchdog on the core result: AES_STREAM_TIMEOUT_EN.   |
// | Revision : 1.0                                                            |
// -----------------------------------------------------------------------------
module aes_block_stream
   import aes_block_stream_pkg::*;
#(
   parameter int BLK_BYTES      = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [7:0]   s_data,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic         flush,
   output logic [127:0] pt,
   output logic         load,
   input  logic [127:0] ct,
   input  logic         ct_valid,
   output logic [7:0]   m_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic         busy,
   output logic [7:0]   blk_cnt,
   output logic         err
);

   localparam logic [1:0] c_st_fill  = FILL;
   localparam logic [1:0] c_st_load  = LOAD;
   localparam logic [1:0] c_st_wait  = WAIT;
   localparam logic [1:0] c_st_drain = DRAIN;
   localparam logic [3:0] c_last_idx = 4'(BLK_BYTES - 1);

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic [3:0]  r_idx;
   aes_block_t  r_pt;
   aes_block_t  r_ct;
   aes_byte_t   r_m_data;
   logic        r_s_ready;
   logic [7:0]  r_blk_cnt;
   logic        w_fill_acc;
   logic        w_drain_acc;
   logic        w_last_idx;

`ifdef AES_STREAM_TIMEOUT_EN
   logic [15:0] r_wd_cnt;
   logic        r_err;
   logic        w_timeout;
`else
   logic [31:0] w_unused_timeout;
   assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

   // flush takes priority over a byte offered in the same cycle
   assign w_fill_acc  = (r_state == c_st_fill) && s_valid && r_s_ready && !flush;
   assign w_drain_acc = (r_state == c_st_drain) && m_ready;
   assign w_last_idx  = (r_idx == c_last_idx);

   always_comb begin
      w_state_nxt = r_state;
`ifdef AES_STREAM_TIMEOUT_EN
      w_timeout   = 1'b0;
`endif
      case (r_state)
         c_st_fill:  if (w_fill_acc && w_last_idx) w_state_nxt = c_st_load;
         c_st_load:  w_state_nxt = c_st_wait;
         c_st_wait: begin
            if (ct_valid) begin
               w_state_nxt = c_st_drain;
            end
`ifdef AES_STREAM_TIMEOUT_EN
            else if (r_wd_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
               w_timeout   = 1'b1;
               w_state_nxt = c_st_fill;
            end
`endif
         end
         c_st_drain: if (w_drain_acc && w_last_idx) w_state_nxt = c_st_fill;
         default:    w_state_nxt = c_st_fill;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= c_st_fill;
         r_idx     <= 4'd0;
         r_pt      <= '0;
         r_ct      <= '0;
         r_m_data  <= '0;
         r_s_ready <= 1'b0;
         r_blk_cnt <= 8'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_s_ready <= (w_state_nxt == c_st_fill);
         case (r_state)
            c_st_fill: begin
               if (flush) begin
                  r_idx <= 4'd0;
               end else if (w_fill_acc) begin
                  r_pt[byte_msb(r_idx) -: 8] <= s_data;
                  r_idx                      <= w_last_idx ? 4'd0 : r_idx + 4'd1;
               end
            end
            c_st_wait: begin
               if (ct_valid) begin
                  r_ct     <= ct;
                  r_m_data <= ct[127:120];
               end
            end
            c_st_drain: begin
               if (w_drain_acc) begin
                  if (w_last_idx) begin
                     r_idx     <= 4'd0;
                     r_blk_cnt <= r_blk_cnt + 8'd1;
                  end else begin
                     r_idx    <= r_idx + 4'd1;
                     r_m_data <= r_ct[byte_msb(r_idx + 4'd1) -: 8];
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef AES_STREAM_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wd_cnt <= 16'd0;
         r_err    <= 1'b0;
      end else begin
         if (r_state == c_st_load) begin
            r_wd_cnt <= 16'd0;
         end else if (r_state == c_st_wait) begin
            r_wd_cnt <= r_wd_cnt + 16'd1;
         end
         if (w_timeout) begin
            r_err <= 1'b1;
         end
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   assign s_ready = r_s_ready;
   assign pt      = r_pt;
   assign load    = (r_state == c_st_load);
   assign m_valid = (r_state == c_st_drain);
   assign m_data  = r_m_data;
   assign busy    = (r_state != c_st_fill);
   assign blk_cnt = r_blk_cnt;

endmodule
`default_nettype wire
